// File: rtl/unidad_pc_branch.sv
// PC stage: holds the architectural PC, applies branch/jump redirects and drives the post-redirect flush window.
// Optional macro PC_PERF_COUNTERS_EN builds the taken-branch and jump counters; otherwise they read 0.
module unidad_pc_branch #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] target_addr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                flush,
    output logic                instr_valid,
    output logic                misalign_err,
    output logic [PC_WIDTH-1:0] br_count,
    output logic [PC_WIDTH-1:0] jmp_count
);

    localparam int unsigned         CNT_W      = 3;
    localparam logic [CNT_W-1:0]    FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    flush_cnt;
    logic                redirect;
    logic                misaligned;
    logic [PC_WIDTH-1:0] target_aligned;

    assign redirect       = (branch_taken | jump) & ~stall;
    assign misaligned     = (target_addr[1:0] != 2'b00);
    assign target_aligned = {target_addr[PC_WIDTH-1:2], 2'b00};

    // PC, flush window and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            pc_out       <= RESET_PC;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
            pc_out    <= target_aligned;
            if (misaligned) begin
                misalign_err <= 1'b1;
            end
        end else if (!stall) begin
            pc_out <= pc_out + PC_STEP;
            case (state)
                RUN: begin
                    flush_cnt <= '0;
                end
                FLUSH: begin
                    if (flush_cnt <= CNT_ONE) begin
                        state     <= RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PC_PERF_COUNTERS_EN
    // Both controls high counts as a jump
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count  <= '0;
            jmp_count <= '0;
        end else if (redirect) begin
            if (jump) begin
                jmp_count <= jmp_count + PC_WIDTH'(1);
            end else begin
                br_count <= br_count + PC_WIDTH'(1);
            end
        end
    end
`else
    assign br_count  = '0;
    assign jmp_count = '0;
`endif

    assign pc_plus4    = pc_out + PC_STEP;
    assign flush       = (state == FLUSH);
    assign instr_valid = ~flush & ~rst;

endmodule

// File: tb/tb_unidad_pc_branch.sv
// Bench for unidad_pc_branch: vector table plus a hand sequence, expected values queued at drive time.
module tb_unidad_pc_branch;

    localparam int unsigned W = 32;

`ifdef PC_PERF_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic         rst;
        logic         stall;
        logic         br;
        logic         jmp;
        logic [W-1:0] tgt;
        logic [W-1:0] pc;
        logic         fl;
        logic         v;
        logic         mis;
        logic [W-1:0] bc;
        logic [W-1:0] jc;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, stall, branch_taken, jump;
    logic [W-1:0] target_addr;
    logic [W-1:0] pc_out, pc_plus4, br_count, jmp_count;
    logic         flush, instr_valid, misalign_err;

    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    logic prev_fl  = 1'b0;
    vec_t exp_q[$];
    vec_t vecs[32];
    int   nvec = 0;

    unidad_pc_branch #(
        .PC_WIDTH    (W),
        .RESET_PC    (32'h0000_0100),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .jump        (jump),
        .target_addr (target_addr),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .flush       (flush),
        .instr_valid (instr_valid),
        .misalign_err(misalign_err),
        .br_count    (br_count),
        .jmp_count   (jmp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic b, input logic j,
                       input logic [W-1:0] t, input logic [W-1:0] pc, input logic fl,
                       input logic mis, input logic [W-1:0] bc, input logic [W-1:0] jc);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.jmp = j; v.tgt = t;
        v.pc = pc; v.fl = fl; v.v = !r && !fl; v.mis = mis;
        v.bc = CNT_EN ? bc : '0;
        v.jc = CNT_EN ? jc : '0;
        vecs[nvec] = v;
        nvec++;
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; stall = v.stall; branch_taken = v.br; jump = v.jmp; target_addr = v.tgt;
        #1;
        check("instr_valid_now", W'(instr_valid), W'(!v.rst && !prev_fl));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pc_out",       pc_out,              e.pc);
        check("pc_plus4",     pc_plus4,            e.pc + W'(4));
        check("flush",        W'(flush),           W'(e.fl));
        check("instr_valid",  W'(instr_valid),     W'(e.v));
        check("misalign_err", W'(misalign_err),    W'(e.mis));
        check("br_count",     br_count,            e.bc);
        check("jmp_count",    jmp_count,           e.jc);
        prev_fl = e.fl;
        step_no++;
        @(negedge clk);
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; target_addr = '0;

        //   rst stl br jmp target          pc              fl mis bc jc
        add(1, 0, 0, 0, 32'h0,          32'h0000_0100, 0, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0,          32'h0000_0100, 0, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0,          32'h0000_0100, 0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0104, 0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0108, 0, 0, 0, 0);
        add(0, 0, 1, 0, 32'h200,        32'h0000_0200, 1, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0204, 1, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0208, 0, 0, 1, 0);
        add(0, 0, 1, 0, 32'h300,        32'h0000_0300, 1, 0, 2, 0);
        add(0, 1, 1, 0, 32'h700,        32'h0000_0300, 1, 0, 2, 0);
        add(0, 1, 0, 0, 32'h0,          32'h0000_0300, 1, 0, 2, 0);
        add(0, 1, 0, 0, 32'h0,          32'h0000_0300, 1, 0, 2, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0304, 1, 0, 2, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0308, 0, 0, 2, 0);
        add(0, 0, 1, 0, 32'h200,        32'h0000_0200, 1, 0, 3, 0);
        add(0, 0, 1, 0, 32'h300,        32'h0000_0300, 1, 0, 4, 0);
        add(0, 0, 1, 1, 32'h400,        32'h0000_0400, 1, 0, 4, 1);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0404, 1, 0, 4, 1);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0408, 0, 0, 4, 1);
        add(0, 0, 0, 1, 32'h502,        32'h0000_0500, 1, 1, 4, 2);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0504, 1, 1, 4, 2);
        add(1, 0, 0, 0, 32'h0,          32'h0000_0100, 0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0104, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1, 0, 0, 1);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0, 1);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0004, 0, 0, 0, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0000_0004, 0, 0, 0, 1);
        add(0, 0, 0, 0, 32'h0,          32'h0000_0008, 0, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            apply(vecs[i]);
        end

        // Jump held through a RUN-state stall is taken only once stall drops
        h = vecs[0];
        h.rst = 0; h.stall = 1; h.br = 0; h.jmp = 1; h.tgt = 32'h40;
        h.pc = 32'h8; h.fl = 0; h.v = 1; h.mis = 0;
        h.bc = '0; h.jc = CNT_EN ? W'(1) : '0;
        apply(h);
        apply(h);
        h.stall = 0; h.pc = 32'h40; h.fl = 1; h.v = 0;
        h.jc = CNT_EN ? W'(2) : '0;
        apply(h);
        h.jmp = 0; h.pc = 32'h44;
        apply(h);
        h.pc = 32'h48; h.fl = 0; h.v = 1;
        apply(h);

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
